// File: rtl/spi_ram_pkg.sv
// rtl/spi_ram_pkg.sv - shared command codes, FSM states and defaults for the SPI/host RAM arbiter
package spi_ram_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    localparam int DEF_ADDR_SIZE = 8;
    localparam int SPI_DATA_W    = 8;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        ACC   = 2'd1,
        RWAIT = 2'd2
    } state_t;

endpackage

// File: rtl/spi_cmd_decoder.sv
// rtl/spi_cmd_decoder.sv - turns 10-bit SPI command words into one pending RAM operation
// Address latches are internal; the pending op captures its address when the data/read command lands.
module spi_cmd_decoder
    import spi_ram_pkg::*;
#(
    parameter int ADDR_SIZE = DEF_ADDR_SIZE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [9:0]           rx_data,
    input  logic                 rx_valid,
    input  logic                 spi_grant,
    output logic                 new_cmd,
    output logic                 spi_pend,
    output logic                 spi_we,
    output logic [ADDR_SIZE-1:0] spi_addr,
    output logic [7:0]           spi_wdata
);

    logic                 rx_valid_q;
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic [1:0]           cmd;
    logic [7:0]           payload;

    assign cmd     = rx_data[9:8];
    assign payload = rx_data[7:0];
    assign new_cmd = rx_valid & ~rx_valid_q;

    // A command landing in the grant cycle must survive, so the set below wins over the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid_q <= 1'b0;
            wr_addr    <= '0;
            rd_addr    <= '0;
            spi_pend   <= 1'b0;
            spi_we     <= 1'b0;
            spi_addr   <= '0;
            spi_wdata  <= '0;
        end else begin
            rx_valid_q <= rx_valid;
            if (spi_grant) begin
                spi_pend <= 1'b0;
            end
            if (new_cmd) begin
                case (cmd)
                    CMD_WR_ADDR: wr_addr <= ADDR_SIZE'(payload);
                    CMD_WR_DATA: begin
                        spi_pend  <= 1'b1;
                        spi_we    <= 1'b1;
                        spi_addr  <= wr_addr;
                        spi_wdata <= payload;
                    end
                    CMD_RD_ADDR: rd_addr <= ADDR_SIZE'(payload);
                    default: begin
                        spi_pend <= 1'b1;
                        spi_we   <= 1'b0;
                        spi_addr <= rd_addr;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/spi_ram_arbiter.sv
// rtl/spi_ram_arbiter.sv - shares one single-port RAM between the SPI command path and a host port
// Define SPI_ARB_FIXED_PRIO_EN to give SPI fixed priority instead of round-robin.
module spi_ram_arbiter
    import spi_ram_pkg::*;
#(
    parameter int ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int DATA_W    = SPI_DATA_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [9:0]           rx_data,
    input  logic                 rx_valid,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 h_req,
    input  logic                 h_we,
    input  logic [ADDR_SIZE-1:0] h_addr,
    input  logic [DATA_W-1:0]    h_wdata,
    output logic                 h_gnt,
    output logic [DATA_W-1:0]    h_rdata,
    output logic                 h_rvalid,
    output logic                 ram_en,
    output logic                 ram_we,
    output logic [ADDR_SIZE-1:0] ram_addr,
    output logic [DATA_W-1:0]    ram_din,
    input  logic [DATA_W-1:0]    ram_dout
);

    state_t               state;
    state_t               state_nxt;
    logic                 new_cmd;
    logic                 spi_pend;
    logic                 spi_we;
    logic [ADDR_SIZE-1:0] spi_addr;
    logic [7:0]           spi_wdata;
    logic                 spi_win;
    logic                 host_win;
    logic                 spi_grant;
    logic                 grant;
    logic                 cur_host;

    spi_cmd_decoder #(
        .ADDR_SIZE(ADDR_SIZE)
    ) u_cmd_decoder (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .spi_grant(spi_grant),
        .new_cmd  (new_cmd),
        .spi_pend (spi_pend),
        .spi_we   (spi_we),
        .spi_addr (spi_addr),
        .spi_wdata(spi_wdata)
    );

`ifdef SPI_ARB_FIXED_PRIO_EN
    assign spi_win = spi_pend;
`else
    logic rr_spi;

    assign spi_win = spi_pend & (rr_spi | ~h_req);

    // After a contended grant the pointer favours whoever just lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_spi <= 1'b1;
        end else if (state == ARB && spi_pend && h_req) begin
            rr_spi <= ~spi_win;
        end
    end
`endif

    assign host_win = h_req & ~spi_win;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB:     if (spi_win || host_win) state_nxt = ACC;
            ACC:     state_nxt = ram_we ? ARB : RWAIT;
            RWAIT:   state_nxt = ARB;
            default: state_nxt = ARB;
        endcase
    end

    always_comb begin
        h_gnt     = 1'b0;
        spi_grant = 1'b0;
        grant     = 1'b0;
        if (state == ARB) begin
            h_gnt     = host_win;
            spi_grant = spi_win;
            grant     = spi_win | host_win;
        end
    end

    // ram_en follows grant by one cycle, so it is high only in ACC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_en   <= 1'b0;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
            cur_host <= 1'b0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            h_rdata  <= '0;
            h_rvalid <= 1'b0;
        end else begin
            ram_en   <= grant;
            h_rvalid <= 1'b0;
            if (grant) begin
                cur_host <= host_win;
                ram_we   <= spi_grant ? spi_we : h_we;
                ram_addr <= spi_grant ? spi_addr : h_addr;
                ram_din  <= spi_grant ? DATA_W'(spi_wdata) : h_wdata;
            end
            if (state == RWAIT && !cur_host) begin
                tx_data  <= 8'(ram_dout);
                tx_valid <= 1'b1;
            end else if (new_cmd) begin
                tx_valid <= 1'b0;
            end
            if (state == RWAIT && cur_host) begin
                h_rdata  <= ram_dout;
                h_rvalid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// tb/tb_spi_ram_arbiter.sv - self-checking bench for spi_ram_arbiter
// Directed vector table, contention and reset sequences, then random traffic against a slot-based model.
module tb_spi_ram_arbiter;
    import spi_ram_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       h_req;
    logic       h_we;
    logic [7:0] h_addr;
    logic [7:0] h_wdata;
    logic       h_gnt;
    logic [7:0] h_rdata;
    logic       h_rvalid;
    logic       ram_en;
    logic       ram_we;
    logic [7:0] ram_addr;
    logic [7:0] ram_din;
    bit   [7:0] ram_dout;

    spi_ram_arbiter #(.ADDR_SIZE(8), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .h_req(h_req), .h_we(h_we),
        .h_addr(h_addr), .h_wdata(h_wdata), .h_gnt(h_gnt), .h_rdata(h_rdata),
        .h_rvalid(h_rvalid), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bit [7:0] mem [256];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_din;
            else        ram_dout <= mem[ram_addr];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: one access in flight, tracked as "free at" and event slots.
    bit [7:0]   mm [256];
    int         cyc = 0;
    int         free_at, strobe_at, hr_at, tx_at;
    logic       m_prev_rxv, m_pend, m_pend_we, m_fav_spi, clr_tx;
    logic [7:0] m_wr_addr, m_rd_addr, m_pend_addr, m_pend_data;
    logic       s_we;
    logic [7:0] s_addr, s_din, hr_data, tx_d;
    logic       e_tx_valid, e_h_rvalid;
    logic [7:0] e_tx_data, e_h_rdata;

    task automatic model_reset();
        free_at = 0; strobe_at = -1; hr_at = -1; tx_at = -1;
        m_prev_rxv = 0; m_pend = 0; m_pend_we = 0; m_fav_spi = 1; clr_tx = 0;
        m_wr_addr = 0; m_rd_addr = 0; m_pend_addr = 0; m_pend_data = 0;
        e_tx_valid = 0; e_h_rvalid = 0; e_tx_data = 0; e_h_rdata = 0;
    endtask

    task automatic model_step();
        logic idle, spi_w, host_w, newc, we;
        logic [7:0] a, d;
        if (clr_tx) e_tx_valid = 0;
        clr_tx = 0;
        if (tx_at == cyc) begin e_tx_valid = 1; e_tx_data = tx_d; end
        e_h_rvalid = (hr_at == cyc);
        if (e_h_rvalid) e_h_rdata = hr_data;
        chk("m_ram_en", ram_en, strobe_at == cyc);
        if (strobe_at == cyc) begin
            chk("m_ram_we", ram_we, s_we);
            chk("m_ram_addr", ram_addr, s_addr);
            if (s_we) chk("m_ram_din", ram_din, s_din);
        end
        chk("m_tx_valid", tx_valid, e_tx_valid);
        if (e_tx_valid) chk("m_tx_data", tx_data, e_tx_data);
        chk("m_h_rvalid", h_rvalid, e_h_rvalid);
        if (e_h_rvalid) chk("m_h_rdata", h_rdata, e_h_rdata);

        idle = (cyc >= free_at);
`ifdef SPI_ARB_FIXED_PRIO_EN
        spi_w = idle && m_pend;
`else
        spi_w = idle && m_pend && (!h_req || m_fav_spi);
        if (idle && m_pend && h_req) m_fav_spi = !spi_w;
`endif
        host_w = idle && h_req && !spi_w;
        chk("m_h_gnt", h_gnt, host_w);
        if (spi_w || host_w) begin
            we = spi_w ? m_pend_we : h_we;
            a  = spi_w ? m_pend_addr : h_addr;
            d  = spi_w ? m_pend_data : h_wdata;
            strobe_at = cyc + 1; s_we = we; s_addr = a; s_din = d;
            if (we) begin
                mm[a] = d;
                free_at = cyc + 2;
            end else begin
                free_at = cyc + 3;
                if (spi_w) begin tx_at = cyc + 3; tx_d = mm[a]; end
                else       begin hr_at = cyc + 3; hr_data = mm[a]; end
            end
            if (spi_w) m_pend = 0;
        end

        newc = rx_valid && !m_prev_rxv;
        m_prev_rxv = rx_valid;
        if (newc) begin
            clr_tx = 1;
            case (rx_data[9:8])
                CMD_WR_ADDR: m_wr_addr = rx_data[7:0];
                CMD_WR_DATA: begin m_pend = 1; m_pend_we = 1; m_pend_addr = m_wr_addr; m_pend_data = rx_data[7:0]; end
                CMD_RD_ADDR: m_rd_addr = rx_data[7:0];
                default:     begin m_pend = 1; m_pend_we = 0; m_pend_addr = m_rd_addr; end
            endcase
        end
    endtask

    logic       n_rx_valid, n_h_req, n_h_we;
    logic [9:0] n_rx_data;
    logic [7:0] n_h_addr, n_h_wdata;

    task automatic cycle();
        @(posedge clk);
        #1;
        rx_valid = n_rx_valid; rx_data = n_rx_data;
        h_req = n_h_req; h_we = n_h_we; h_addr = n_h_addr; h_wdata = n_h_wdata;
        #1;
        cyc++;
        model_step();
    endtask

    task automatic spi_word(input logic [1:0] c, input logic [7:0] p);
        n_rx_valid = 1; n_rx_data = {c, p};
        cycle();
        n_rx_valid = 0;
        cycle();
    endtask

    typedef struct {
        logic       host;
        logic       we;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    task automatic do_spi(input vec_t v);
        repeat (2) cycle();
        spi_word(v.we ? CMD_WR_ADDR : CMD_RD_ADDR, v.addr);
        spi_word(v.we ? CMD_WR_DATA : CMD_RD_DATA, v.we ? v.data : 8'h00);
        chk("spi_no_hgnt", h_gnt, 0);
        cycle();
        chk("spi_strobe", ram_en, 1);
        chk("spi_we", ram_we, v.we);
        chk("spi_addr", ram_addr, v.addr);
        if (v.we) chk("spi_din", ram_din, v.data);
        cycle();
        chk("spi_strobe_one", ram_en, 0);
        if (!v.we) begin
            cycle();
            chk("spi_tx_valid", tx_valid, 1);
            chk("spi_tx_data", tx_data, v.exp);
            repeat (3) cycle();
            chk("spi_tx_held", tx_valid, 1);
            spi_word(CMD_RD_ADDR, v.addr);
            chk("spi_tx_clear", tx_valid, 0);
        end
    endtask

    task automatic do_host(input vec_t v);
        repeat (2) cycle();
        n_h_req = 1; n_h_we = v.we; n_h_addr = v.addr; n_h_wdata = v.data;
        cycle();
        chk("h_gnt_req_cycle", h_gnt, 1);
        n_h_req = 0;
        cycle();
        chk("h_strobe", ram_en, 1);
        chk("h_we", ram_we, v.we);
        chk("h_addr", ram_addr, v.addr);
        if (v.we) chk("h_din", ram_din, v.data);
        cycle();
        chk("h_strobe_one", ram_en, 0);
        chk("h_rvalid_early", h_rvalid, 0);
        if (!v.we) begin
            cycle();
            chk("h_rvalid", h_rvalid, 1);
            chk("h_rdata", h_rdata, v.exp);
            cycle();
            chk("h_rvalid_pulse", h_rvalid, 0);
        end
    endtask

    // SPI re-armed every other cycle, host always requesting; records who owned each strobe.
    task automatic contend4(input string tag);
        int         seen;
        logic       prev_gnt;
        logic [3:0] own;
        logic [3:0] exp_own;
        seen = 0; prev_gnt = 0; own = '0;
`ifdef SPI_ARB_FIXED_PRIO_EN
        exp_own = 4'b0000;
`else
        exp_own = 4'b1010;
`endif
        for (int k = 0; k < 20 && seen < 4; k++) begin
            n_rx_valid = (k % 2 == 0);
            n_rx_data  = {CMD_WR_DATA, 8'(k)};
            n_h_req = (k > 0); n_h_we = 1; n_h_addr = 8'(8'h20 + k); n_h_wdata = 8'(k);
            cycle();
            if (ram_en) begin own[seen] = prev_gnt; seen++; end
            prev_gnt = h_gnt;
        end
        n_rx_valid = 0; n_h_req = 0;
        chk({tag, "_grants"}, seen, 4);
        chk({tag, "_order"}, own, exp_own);
        repeat (8) cycle();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ram_en"}, ram_en, 0);
        chk({tag, "_ram_we"}, ram_we, 0);
        chk({tag, "_ram_addr"}, ram_addr, 0);
        chk({tag, "_ram_din"}, ram_din, 0);
        chk({tag, "_tx_valid"}, tx_valid, 0);
        chk({tag, "_tx_data"}, tx_data, 0);
        chk({tag, "_h_rvalid"}, h_rvalid, 0);
        chk({tag, "_h_rdata"}, h_rdata, 0);
        chk({tag, "_h_gnt"}, h_gnt, 0);
    endtask

    task automatic pulse_reset();
        #1;
        rst_n = 0;
        rx_valid = 0; h_req = 0; n_rx_valid = 0; n_h_req = 0;
        #1;
        check_zero("rwait_rst");
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1;
        model_reset();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        vec_t vec [10];
        int   nwr, spi_cnt, hold;
        logic [1:0] c;
        vec[0] = '{0, 1, 8'h3C, 8'hA5, 8'h00};
        vec[1] = '{0, 0, 8'h3C, 8'h00, 8'hA5};
        vec[2] = '{1, 1, 8'h10, 8'h5A, 8'h00};
        vec[3] = '{1, 0, 8'h10, 8'h00, 8'h5A};
        vec[4] = '{1, 0, 8'h3C, 8'h00, 8'hA5};
        vec[5] = '{0, 0, 8'h10, 8'h00, 8'h5A};
        vec[6] = '{0, 1, 8'h00, 8'hFF, 8'h00};
        vec[7] = '{1, 0, 8'h00, 8'h00, 8'hFF};
        vec[8] = '{1, 1, 8'h3C, 8'h00, 8'h00};
        vec[9] = '{0, 0, 8'h3C, 8'h00, 8'h00};

        rst_n = 0; rx_valid = 0; rx_data = '0; h_req = 0; h_we = 0; h_addr = '0; h_wdata = '0;
        n_rx_valid = 0; n_rx_data = '0; n_h_req = 0; n_h_we = 0; n_h_addr = '0; n_h_wdata = '0;
        model_reset();
        @(posedge clk);
        #2;
        check_zero("reset");
        @(posedge clk);
        #2 rst_n = 1;

        contend4("rr_after_reset");

        for (int i = 0; i < 10; i++) begin
            if (vec[i].host) do_host(vec[i]);
            else             do_spi(vec[i]);
        end

        nwr = 0;
        n_rx_data = {CMD_WR_DATA, 8'h77}; n_rx_valid = 1;
        repeat (5) begin cycle(); if (ram_en) nwr++; end
        n_rx_valid = 0;
        repeat (6) begin cycle(); if (ram_en) nwr++; end
        chk("held_rx_writes", nwr, 1);

        repeat (4) cycle();
        n_rx_valid = 1; n_rx_data = {CMD_RD_DATA, 8'h00};
        cycle();
        n_rx_valid = 0; n_h_req = 1; n_h_we = 1; n_h_addr = 8'h44; n_h_wdata = 8'h99;
        cycle();
        chk("pre_rst_spi_wins", h_gnt, 0);
        cycle();
        cycle();
        pulse_reset();
        cycle();
        chk("post_rst_tx_valid", tx_valid, 0);
        chk("post_rst_h_rvalid", h_rvalid, 0);
        repeat (4) cycle();
        chk("post_rst_tx_quiet", tx_valid, 0);
        contend4("rr_after_rwait_reset");

        spi_cnt = 0; hold = 0;
        for (int i = 0; i < 600; i++) begin
            if (spi_cnt == 0) begin
                spi_cnt = $urandom_range(10, 14);
                hold = $urandom_range(1, 3);
                c = 2'($urandom_range(0, 3));
                n_rx_data = {c, (c == CMD_WR_DATA) ? 8'($urandom) : 8'($urandom_range(0, 7))};
            end
            n_rx_valid = (hold > 0);
            if (hold > 0) hold--;
            spi_cnt--;
            if (!n_h_req && $urandom_range(0, 2) == 0) begin
                n_h_req = 1;
                n_h_we = 1'($urandom_range(0, 1));
                n_h_addr = 8'($urandom_range(0, 7));
                n_h_wdata = 8'($urandom);
            end
            cycle();
            if (h_gnt) n_h_req = 0;
        end
        n_rx_valid = 0; n_h_req = 0;
        repeat (10) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_ram_arbiter.md
Name: spi_ram_arbiter

Overview:
- Sits between the SPI slave, the single-port RAM and a local host port.
- Decodes the SPI slave's 10-bit command words into RAM accesses.
- Shares the one RAM port between the SPI path and the host using round-robin arbitration.
- Returns SPI read data through tx_data/tx_valid and host read data through h_rdata/h_rvalid.

Parameters:
- ADDR_SIZE, 8, RAM address width.
- DATA_W, 8, RAM data width; the SPI payload is fixed at 8, so DATA_W must equal 8.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- rx_data  in  10  SPI command word; [9:8] = cmd, [7:0] = payload
- rx_valid  in  1  level from SPI slave; may stay high for several cycles
- tx_data  out  8  SPI read data
- tx_valid  out  1  SPI read data valid (level)
- h_req  in  1  host request; held until h_gnt
- h_we  in  1  host write(1) / read(0)
- h_addr  in  ADDR_SIZE  host address
- h_wdata  in  DATA_W  host write data
- h_gnt  out  1  combinational; request accepted this cycle
- h_rdata  out  DATA_W  host read data
- h_rvalid  out  1  one-cycle pulse
- ram_en  out  1  registered RAM access strobe
- ram_we  out  1  registered RAM write enable
- ram_addr  out  ADDR_SIZE  registered RAM address
- ram_din  out  DATA_W  registered RAM write data
- ram_dout  in  DATA_W  RAM read data, valid the cycle after ram_en=1 with ram_we=0

Behaviour:
- Reset (async, rst_n=0):
  - All outputs go to 0.
  - wr_addr, rd_addr, spi_pend, rx_valid_q all clear.
  - Round-robin pointer is set to favour SPI.
  - FSM goes to ARB.
  - An access in flight is dropped: no tx_valid, no h_rvalid.
- Command detect:
  - rx_valid_q registers rx_valid; a new command is rx_valid & ~rx_valid_q.
  - A held rx_valid produces exactly one command.
- Command decode, on a new command:
  - cmd 00: wr_addr <= payload. No RAM access.
  - cmd 01: spi_pend <= 1, spi_op = write, data = payload, address = the wr_addr held at that moment.
  - cmd 10: rd_addr <= payload. No RAM access.
  - cmd 11: spi_pend <= 1, spi_op = read at rd_addr. The payload is ignored.
  - Any new command clears tx_valid.
- FSM states: ARB, ACC, RWAIT.
  - ARB: pick a winner among spi_pend and h_req.
    - Both requesting: the round-robin pointer decides, then the pointer flips to the loser.
    - Host wins: h_gnt=1 in this cycle.
    - Spi wins: spi_pend clears.
    - Winner's operation is registered onto ram_*; next state ACC.
    - No requester: ram_en=0, stay in ARB.
  - ACC: ram_en=1 for exactly one cycle. Write -> ARB. Read -> RWAIT.
  - RWAIT: capture ram_dout.
    - Host read: h_rdata = captured data, h_rvalid=1 for one cycle, starting the cycle the FSM re-enters ARB.
    - SPI read: tx_data = captured data, tx_valid=1, held until the next new command.
    - Next state ARB.
- Latency, uncontended, grant cycle T:
  - RAM strobe at T+1.
  - Read result at T+3.
  - Next grant possible at T+2 after a write, T+3 after a read.
- Boundaries:
  - h_gnt is only ever asserted in ARB.
  - A new SPI command arriving while spi_pend=1 overwrites the pending op. Round-robin bounds SPI service to 6 cycles, below the 10-cycle SPI word time, so this cannot occur in normal operation.
  - An address latch (cmd 00/10) arriving while an SPI access is in flight does not affect that access, since the address was captured at grant.

Optional Feature:
- Macro: SPI_ARB_FIXED_PRIO_EN.
- Defined: SPI always wins over host on contention; the round-robin pointer is removed.
- Undefined: round-robin as described above.

Decomposition:
- Package spi_ram_pkg holds:
  - cmd constants CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11;
  - the FSM state enum (ARB, ACC, RWAIT);
  - default ADDR_SIZE.
- One sub-module, spi_cmd_decoder, contains the edge detect, wr_addr/rd_addr latches, spi_pend and spi_op.
- Arbitration and the FSM stay in the top.

Test Plan:
- SPI write: edge with 00_3C, then edge with 01_A5 -> exactly one cycle of ram_en=1, ram_we=1, ram_addr=3C, ram_din=A5; h_gnt stays 0.
- SPI read: 10_3C, then 11_00, with the RAM model returning A5 -> tx_data=A5, tx_valid=1 three cycles after grant; held until the next rx_valid edge, then 0.
- Host write then read at addr 10, data 5A -> h_gnt in the request cycle; write strobe at T+1; on the read, h_rvalid is a one-cycle pulse with h_rdata=5A at T+3.
- Contention right after reset (spi_pend and h_req together, repeated 4 times) -> grants go SPI, host, SPI, host. With SPI_ARB_FIXED_PRIO_EN defined, all SPI grants come first.
- rx_valid held high 5 cycles with 01_77 -> only one RAM write.
- rst_n pulsed low during RWAIT -> all outputs 0 immediately; no tx_valid/h_rvalid after release; the next grant favours SPI.
